// File: rtl/light_pkg.sv
// Shared definitions for the light conflict monitor.
// Holds the light-code encodings, fault-code values, FSM state type
// and a one-hot legality helper used by the per-direction trackers.
package light_pkg;

    localparam int unsigned LT_W  = 3;
    localparam int unsigned FLT_W = 3;

    // Light codes: bit 2 = red, bit 1 = yellow, bit 0 = green
    localparam logic [LT_W-1:0] LT_RED = 3'b100;
    localparam logic [LT_W-1:0] LT_YEL = 3'b010;
    localparam logic [LT_W-1:0] LT_GRN = 3'b001;
    localparam logic [LT_W-1:0] LT_OFF = 3'b000;

    // Fault codes, lower value wins when several fire together
    localparam logic [FLT_W-1:0] FLT_NONE     = 3'd0;
    localparam logic [FLT_W-1:0] FLT_ILLEGAL  = 3'd1;
    localparam logic [FLT_W-1:0] FLT_CONFLICT = 3'd2;
    localparam logic [FLT_W-1:0] FLT_SEQ      = 3'd3;
    localparam logic [FLT_W-1:0] FLT_SHORT_Y  = 3'd4;
    localparam logic [FLT_W-1:0] FLT_STUCK    = 3'd5;

    typedef enum logic {
        PASS  = 1'b0,
        FLASH = 1'b1
    } state_e;

    // True for the three legal one-hot codes only
    function automatic logic is_legal(input logic [LT_W-1:0] code);
        return (code == LT_RED) || (code == LT_YEL) || (code == LT_GRN);
    endfunction

endpackage

// File: rtl/light_conflict_monitor_if.sv
// Bus between the traffic controller, the conflict monitor and the lamp drivers.
// Signals:
//   ns_in/ew_in   - light codes from the controller
//   fault_clr     - operator clear pulse
//   ns_out/ew_out - lamp drive codes
//   fault         - monitor is flashing red
//   fault_code    - latched fault cause
// master = controller/operator side, slave = monitor.
interface light_conflict_monitor_if;
    import light_pkg::*;

    logic [LT_W-1:0]  ns_in;
    logic [LT_W-1:0]  ew_in;
    logic             fault_clr;
    logic [LT_W-1:0]  ns_out;
    logic [LT_W-1:0]  ew_out;
    logic             fault;
    logic [FLT_W-1:0] fault_code;

    modport master (
        output ns_in, ew_in, fault_clr,
        input  ns_out, ew_out, fault, fault_code
    );

    modport slave (
        input  ns_in, ew_in, fault_clr,
        output ns_out, ew_out, fault, fault_code
    );

endinterface

// File: rtl/light_dir_tracker.sv
// Per-direction history tracker: previous light code and dwell counter.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   restart_i     - force the dwell counter back to 1 (accepted clear)
//   code_i        - current light code for this direction
//   illegal_c_o   - code_i is not one-hot
//   bad_seq_c_o   - R->Y, Y->G or G->R transition
//   short_y_c_o   - Y->R with yellow held fewer than MIN_YELLOW cycles
//   stuck_c_o     - current code held more than MAX_DWELL cycles
// Flags are combinational on code_i; the top level registers the result.
module light_dir_tracker
    import light_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MAX_DWELL  = 1000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart_i,
    input  logic [LT_W-1:0] code_i,
    output logic            illegal_c_o,
    output logic            bad_seq_c_o,
    output logic            short_y_c_o,
    output logic            stuck_c_o
);

    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] DWELL_SAT = CNT_W'(MAX_DWELL + 1);
    localparam logic [CNT_W-1:0] YEL_MIN   = CNT_W'(MIN_YELLOW);

    logic [LT_W-1:0]  prev_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] dwell_d;

    // dwell_d is the dwell of the current sample; dwell_q that of the previous one
    always_comb begin
        dwell_d     = DWELL_ONE;
        illegal_c_o = 1'b0;
        bad_seq_c_o = 1'b0;
        short_y_c_o = 1'b0;
        stuck_c_o   = 1'b0;

        if (code_i == prev_q) begin
            dwell_d = (dwell_q >= DWELL_SAT) ? DWELL_SAT : dwell_q + DWELL_ONE;
        end

        illegal_c_o = !is_legal(code_i);
        bad_seq_c_o = ((prev_q == LT_RED) && (code_i == LT_YEL)) ||
                      ((prev_q == LT_YEL) && (code_i == LT_GRN)) ||
                      ((prev_q == LT_GRN) && (code_i == LT_RED));
        short_y_c_o = (prev_q == LT_YEL) && (code_i == LT_RED) && (dwell_q < YEL_MIN);
        stuck_c_o   = (dwell_d > DWELL_MAX);
    end

    // History keeps tracking the inputs in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= LT_RED;
            dwell_q <= DWELL_ONE;
        end else begin
            prev_q  <= code_i;
            dwell_q <= restart_i ? DWELL_ONE : dwell_d;
        end
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Passes legal NS/EW codes through with one cycle of latency; on any
// illegal, conflicting, out-of-sequence, short-yellow or stuck condition it
// latches a fault code and flashes red on both directions until an
// operator clear arrives while both inputs are red.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of light_conflict_monitor_if (codes, clear, lamps, fault)
module light_conflict_monitor
    import light_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MAX_DWELL  = 1000,
    parameter int unsigned FLASH_HALF = 50,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    light_conflict_monitor_if.slave  bus
);

    localparam logic [CNT_W-1:0] FLASH_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] FLASH_END = CNT_W'(FLASH_HALF);

    state_e           state_q;
    logic [LT_W-1:0]  ns_out_q;
    logic [LT_W-1:0]  ew_out_q;
    logic             fault_q;
    logic [FLT_W-1:0] fault_code_q;
    logic [CNT_W-1:0] flash_cnt_q;

    logic ns_ill_c, ns_seq_c, ns_short_c, ns_stuck_c;
    logic ew_ill_c, ew_seq_c, ew_short_c, ew_stuck_c;
    logic conflict_c;
    logic clear_ok_c;
    logic restart_c;
    logic [FLT_W-1:0] fault_sel_c;

    assign clear_ok_c = bus.fault_clr && (bus.ns_in == LT_RED) && (bus.ew_in == LT_RED);
    assign restart_c  = (state_q == FLASH) && clear_ok_c;
    assign conflict_c = (bus.ns_in != LT_RED) && (bus.ew_in != LT_RED);

    light_dir_tracker #(
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_DWELL  (MAX_DWELL),
        .CNT_W      (CNT_W)
    ) u_ns (
        .clk         (clk),
        .rst         (rst),
        .restart_i   (restart_c),
        .code_i      (bus.ns_in),
        .illegal_c_o (ns_ill_c),
        .bad_seq_c_o (ns_seq_c),
        .short_y_c_o (ns_short_c),
        .stuck_c_o   (ns_stuck_c)
    );

    light_dir_tracker #(
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_DWELL  (MAX_DWELL),
        .CNT_W      (CNT_W)
    ) u_ew (
        .clk         (clk),
        .rst         (rst),
        .restart_i   (restart_c),
        .code_i      (bus.ew_in),
        .illegal_c_o (ew_ill_c),
        .bad_seq_c_o (ew_seq_c),
        .short_y_c_o (ew_short_c),
        .stuck_c_o   (ew_stuck_c)
    );

    // Priority encoder: lowest fault code wins
    always_comb begin
        fault_sel_c = FLT_NONE;
        if (ns_ill_c || ew_ill_c) begin
            fault_sel_c = FLT_ILLEGAL;
        end else if (conflict_c) begin
            fault_sel_c = FLT_CONFLICT;
        end else if (ns_seq_c || ew_seq_c) begin
            fault_sel_c = FLT_SEQ;
        end else if (ns_short_c || ew_short_c) begin
            fault_sel_c = FLT_SHORT_Y;
        end else if (ns_stuck_c || ew_stuck_c) begin
            fault_sel_c = FLT_STUCK;
        end
    end

    // Monitor FSM with registered lamp outputs and flash phase counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PASS;
            ns_out_q     <= LT_RED;
            ew_out_q     <= LT_RED;
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            flash_cnt_q  <= FLASH_ONE;
        end else begin
            case (state_q)
                PASS: begin
                    if (fault_sel_c != FLT_NONE) begin
                        state_q      <= FLASH;
                        ns_out_q     <= LT_RED;
                        ew_out_q     <= LT_RED;
                        fault_q      <= 1'b1;
                        fault_code_q <= fault_sel_c;
                        flash_cnt_q  <= FLASH_ONE;
                    end else begin
                        ns_out_q <= bus.ns_in;
                        ew_out_q <= bus.ew_in;
                    end
                end
                FLASH: begin
                    if (clear_ok_c) begin
                        state_q      <= PASS;
                        ns_out_q     <= bus.ns_in;
                        ew_out_q     <= bus.ew_in;
                        fault_q      <= 1'b0;
                        fault_code_q <= FLT_NONE;
                    end else if (flash_cnt_q >= FLASH_END) begin
                        // Phase complete: toggle between red and dark
                        ns_out_q    <= (ns_out_q == LT_RED) ? LT_OFF : LT_RED;
                        ew_out_q    <= (ew_out_q == LT_RED) ? LT_OFF : LT_RED;
                        flash_cnt_q <= FLASH_ONE;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + FLASH_ONE;
                    end
                end
                default: begin
                    state_q <= PASS;
                end
            endcase
        end
    end

    assign bus.ns_out     = ns_out_q;
    assign bus.ew_out     = ew_out_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor with MIN_YELLOW=3,
// MAX_DWELL=20, FLASH_HALF=4. Inputs change #1 after a rising edge and
// outputs are checked #1 after the following rising edge.
module tb_light_conflict_monitor;
    import light_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    light_conflict_monitor_if bus ();

    light_conflict_monitor #(
        .MIN_YELLOW (3),
        .MAX_DWELL  (20),
        .FLASH_HALF (4),
        .CNT_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        bus.ns_in     = ns;
        bus.ew_in     = ew;
        bus.fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ns_e, input logic [2:0] ew_e,
                           input logic f_e, input logic [2:0] code_e);
        chk({tag, ".ns_out"}, bus.ns_out, ns_e);
        chk({tag, ".ew_out"}, bus.ew_out, ew_e);
        chk({tag, ".fault"}, {2'b00, bus.fault}, {2'b00, f_e});
        chk({tag, ".code"}, bus.fault_code, code_e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(LT_RED, LT_RED, 1'b0);
        step(LT_RED, LT_RED, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.ns_in     = LT_RED;
        bus.ew_in     = LT_RED;
        bus.fault_clr = 1'b0;

        // 1: reset state, then a legal cycle passes through with one cycle latency
        do_reset();
        chk_all("s1_reset", LT_RED, LT_RED, 1'b0, FLT_NONE);
        for (int i = 0; i < 8; i++) begin
            step(LT_GRN, LT_RED, 1'b0);
            chk_all("s1_ns_grn", LT_GRN, LT_RED, 1'b0, FLT_NONE);
        end
        for (int i = 0; i < 3; i++) begin
            step(LT_YEL, LT_RED, 1'b0);
            chk_all("s1_ns_yel", LT_YEL, LT_RED, 1'b0, FLT_NONE);
        end
        step(LT_RED, LT_RED, 1'b0);
        chk_all("s1_ns_red", LT_RED, LT_RED, 1'b0, FLT_NONE);
        for (int i = 0; i < 2; i++) begin
            step(LT_RED, LT_GRN, 1'b0);
            chk_all("s1_ew_grn", LT_RED, LT_GRN, 1'b0, FLT_NONE);
        end

        // 2: conflict, then flash pattern 100x4, 000x4, 100x4
        do_reset();
        step(LT_RED, LT_RED, 1'b0);
        chk_all("s2_pre", LT_RED, LT_RED, 1'b0, FLT_NONE);
        step(LT_GRN, LT_GRN, 1'b0);
        chk_all("s2_enter", LT_RED, LT_RED, 1'b1, FLT_CONFLICT);
        for (int i = 1; i <= 11; i++) begin
            logic [2:0] e;
            e = (i >= 4 && i <= 7) ? LT_OFF : LT_RED;
            step(LT_RED, LT_RED, 1'b0);
            chk_all("s2_flash", e, e, 1'b1, FLT_CONFLICT);
        end

        // 3a: G->R skipping yellow
        do_reset();
        step(LT_GRN, LT_RED, 1'b0);
        chk_all("s3a_grn", LT_GRN, LT_RED, 1'b0, FLT_NONE);
        step(LT_RED, LT_RED, 1'b0);
        chk_all("s3a_seq", LT_RED, LT_RED, 1'b1, FLT_SEQ);

        // 3b: yellow held only 2 cycles
        do_reset();
        step(LT_GRN, LT_RED, 1'b0);
        step(LT_YEL, LT_RED, 1'b0);
        step(LT_YEL, LT_RED, 1'b0);
        chk_all("s3b_yel", LT_YEL, LT_RED, 1'b0, FLT_NONE);
        step(LT_RED, LT_RED, 1'b0);
        chk_all("s3b_short", LT_RED, LT_RED, 1'b1, FLT_SHORT_Y);

        // 3c: non one-hot code
        do_reset();
        step(3'b011, LT_RED, 1'b0);
        chk_all("s3c_illegal", LT_RED, LT_RED, 1'b1, FLT_ILLEGAL);

        // 3d: illegal beats conflict
        do_reset();
        step(3'b011, LT_GRN, 1'b0);
        chk_all("s3d_prio", LT_RED, LT_RED, 1'b1, FLT_ILLEGAL);

        // 4: NS green and EW red both freshly entered, then held 21 samples
        do_reset();
        step(LT_RED, LT_GRN, 1'b0);
        for (int i = 0; i < 3; i++) step(LT_RED, LT_YEL, 1'b0);
        chk_all("s4_ew_yel", LT_RED, LT_YEL, 1'b0, FLT_NONE);
        for (int i = 1; i <= 20; i++) begin
            step(LT_GRN, LT_RED, 1'b0);
            chk_all("s4_hold", LT_GRN, LT_RED, 1'b0, FLT_NONE);
        end
        step(LT_GRN, LT_RED, 1'b0);
        chk_all("s4_stuck", LT_RED, LT_RED, 1'b1, FLT_STUCK);

        // 5: clear ignored unless both inputs red; ignored in PASS
        do_reset();
        step(LT_RED, LT_RED, 1'b0);
        step(LT_GRN, LT_GRN, 1'b0);
        chk_all("s5_enter", LT_RED, LT_RED, 1'b1, FLT_CONFLICT);
        step(LT_GRN, LT_RED, 1'b1);
        chk_all("s5_clr_ign", LT_RED, LT_RED, 1'b1, FLT_CONFLICT);
        step(LT_RED, LT_RED, 1'b1);
        chk_all("s5_clr_ok", LT_RED, LT_RED, 1'b0, FLT_NONE);
        step(LT_GRN, LT_RED, 1'b0);
        chk_all("s5_resume", LT_GRN, LT_RED, 1'b0, FLT_NONE);
        step(LT_GRN, LT_RED, 1'b1);
        chk_all("s5_clr_pass", LT_GRN, LT_RED, 1'b0, FLT_NONE);

        // 6: reset during the off phase of the flash
        do_reset();
        step(LT_RED, LT_RED, 1'b0);
        step(LT_GRN, LT_GRN, 1'b0);
        for (int i = 0; i < 4; i++) step(LT_RED, LT_RED, 1'b0);
        chk_all("s6_off", LT_OFF, LT_OFF, 1'b1, FLT_CONFLICT);
        rst = 1'b1;
        step(LT_GRN, LT_GRN, 1'b0);
        chk_all("s6_rst", LT_RED, LT_RED, 1'b0, FLT_NONE);
        rst = 1'b0;
        step(LT_GRN, LT_RED, 1'b0);
        chk_all("s6_pass", LT_GRN, LT_RED, 1'b0, FLT_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
